// File: rtl/mem_rmw_unit.sv
// mem_rmw_unit: sub-dword load/store engine over a 64-bit word-addressed memory.
// Loads extract and sign/zero-extend a byte, half, word or dword field. Sub-dword
// stores read the enclosing dword, merge the new bytes and write it back. Dword
// stores write directly. Misaligned requests finish in one cycle without memory traffic.
//
// Ports:
//   i_clk, i_reset        clock, synchronous active-low reset
//   i_start               request strobe, sampled only when idle
//   i_op_store            1 = store, 0 = load
//   i_size                0 = byte, 1 = half, 2 = word, 3 = dword
//   i_sign_ext            loads: 1 = sign-extend, 0 = zero-extend
//   i_addr                byte address
//   i_store_data          store value in the low bytes
//   o_mem_addr            dword-aligned memory address
//   o_mem_rd, o_mem_wr    memory read / write strobes
//   o_mem_wdata           dword written on o_mem_wr
//   i_mem_rdata           read data, valid the cycle after o_mem_rd
//   o_busy, o_done        engine busy, one-cycle completion pulse
//   o_misaligned          qualifies o_done
//   o_load_data           extended load result, held until the next load completes
module mem_rmw_unit #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_op_store,
  input  logic [1:0]        i_size,
  input  logic              i_sign_ext,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_store_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_rd,
  output logic              o_mem_wr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_misaligned,
  output logic [DATA_W-1:0] o_load_data
);

  typedef enum logic [2:0] {StIdle, StRead, StWait, StWrite, StDone} state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic                r_op_store;
  logic [1:0]          r_size;
  logic                r_sign_ext;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_store_data;
  logic [DATA_W-1:0]   r_rdata;
  logic                r_misaligned;
  logic [DATA_W-1:0]   r_load_data;

  logic                w_misaligned_in;
  logic [2:0]          w_offset;
  logic [7:0]          w_byte_en;
  logic [DATA_W-1:0]   w_shifted_sd;
  logic [DATA_W-1:0]   w_merged;
  logic [DATA_W-1:0]   w_field;
  logic [DATA_W-1:0]   w_extract;

  // Alignment of the incoming request, judged before it is latched.
  always_comb begin
    w_misaligned_in = 1'b0;
    case (i_size)
      2'd0:    w_misaligned_in = 1'b0;
      2'd1:    w_misaligned_in = i_addr[0];
      2'd2:    w_misaligned_in = |i_addr[1:0];
      default: w_misaligned_in = |i_addr[2:0];
    endcase
  end

  assign w_offset = r_addr[2:0];

  // Store merge: byte enables and store data both moved up to the byte offset.
  always_comb begin
    w_byte_en = 8'h00;
    case (r_size)
      2'd0:    w_byte_en = 8'h01 << w_offset;
      2'd1:    w_byte_en = 8'h03 << w_offset;
      2'd2:    w_byte_en = 8'h0F << w_offset;
      default: w_byte_en = 8'hFF;
    endcase
  end

  assign w_shifted_sd = r_store_data << {w_offset, 3'b000};

  always_comb begin
    w_merged = r_rdata;
    for (int i = 0; i < 8; i++) begin
      if (w_byte_en[i]) w_merged[8*i +: 8] = w_shifted_sd[8*i +: 8];
    end
  end

  // Load extract works on the live read data so the result is ready on entry to DONE.
  assign w_field = i_mem_rdata >> {w_offset, 3'b000};

  always_comb begin
    w_extract = w_field;
    case (r_size)
      2'd0:    w_extract = {{56{r_sign_ext & w_field[7]}},  w_field[7:0]};
      2'd1:    w_extract = {{48{r_sign_ext & w_field[15]}}, w_field[15:0]};
      2'd2:    w_extract = {{32{r_sign_ext & w_field[31]}}, w_field[31:0]};
      default: w_extract = w_field;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (i_start) begin
          if (w_misaligned_in)                 w_state_next = StDone;
          else if (i_op_store && i_size == 2'd3) w_state_next = StWrite;
          else                                 w_state_next = StRead;
        end
      end
      StRead:  w_state_next = StWait;
      StWait:  w_state_next = r_op_store ? StWrite : StDone;
      StWrite: w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state      <= StIdle;
      r_op_store   <= 1'b0;
      r_size       <= 2'd0;
      r_sign_ext   <= 1'b0;
      r_addr       <= '0;
      r_store_data <= '0;
      r_rdata      <= '0;
      r_misaligned <= 1'b0;
      r_load_data  <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StIdle && i_start) begin
        r_op_store   <= i_op_store;
        r_size       <= i_size;
        r_sign_ext   <= i_sign_ext;
        r_addr       <= i_addr;
        r_store_data <= i_store_data;
        r_misaligned <= w_misaligned_in;
      end
      if (r_state == StWait) begin
        r_rdata <= i_mem_rdata;
        if (!r_op_store) r_load_data <= w_extract;
      end
    end
  end

  assign o_mem_addr   = {r_addr[ADDR_W-1:3], 3'b000};
  assign o_mem_rd     = (r_state == StRead);
  assign o_mem_wr     = (r_state == StWrite);
  assign o_mem_wdata  = (r_state == StWrite) ? w_merged : '0;
  assign o_busy       = (r_state != StIdle);
  assign o_done       = (r_state == StDone);
  assign o_misaligned = (r_state == StDone) && r_misaligned;
  assign o_load_data  = r_load_data;

endmodule

// File: doc/mem_rmw_unit.md
MEM_RMW_UNIT -- requirements
Module: mem_rmw_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, address width.
REQ-002 SHALL have parameter DATA_W, fixed at 64, memory word width; byte lanes are little-endian.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port start, input, 1, request strobe; sampled only in IDLE.
REQ-006 SHALL have port op_store, input, 1, 1=store and 0=load; latched with start.
REQ-007 SHALL have port size, input, 2: 0=byte, 1=half, 2=word, 3=dword; latched with start.
REQ-008 SHALL have port sign_ext, input, 1, loads only: 1=sign-extend, 0=zero-extend; latched with start.
REQ-009 SHALL have port addr, input, ADDR_W, byte address; latched with start.
REQ-010 SHALL have port store_data, input, 64; low bytes supply the store value; latched with start.
REQ-011 SHALL have port mem_addr, output, ADDR_W, dword-aligned address {addr[ADDR_W-1:3],3'b000}.
REQ-012 SHALL have port mem_rd, output, 1, memory read strobe.
REQ-013 SHALL have port mem_wr, output, 1, memory write strobe.
REQ-014 SHALL have port mem_wdata, output, 64, full dword written.
REQ-015 SHALL have port mem_rdata, input, 64; valid exactly one cycle after the cycle mem_rd=1.
REQ-016 SHALL have port busy, output, 1; high in every state except IDLE.
REQ-017 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-018 SHALL have port misaligned, output, 1; qualifies done, high only with done.
REQ-019 SHALL have port load_data, output, 64, extended load result.

Function
REQ-020 SHALL implement states IDLE, READ, WAIT, WRITE, DONE, with outputs decoded from the state register (Moore).
REQ-021 IDLE with start=1 SHALL latch op_store, size, sign_ext, addr and store_data; start in any other state SHALL be ignored.
REQ-022 Alignment: half requires addr[0]=0, word requires addr[1:0]=0, dword requires addr[2:0]=0; byte is always aligned.
REQ-023 Misaligned request: IDLE->DONE with misaligned=1; mem_rd and mem_wr SHALL never assert; load_data unchanged.
REQ-024 Aligned load path SHALL be IDLE->READ->WAIT->DONE; done asserts 3 cycles after the start cycle.
REQ-025 READ SHALL drive mem_rd=1; WAIT SHALL capture mem_rdata into an internal dword register.
REQ-026 Load extract: offset=addr[2:0], field=bytes [offset .. offset+n-1], n=1/2/4/8; result extended to 64 bits per sign_ext; load_data updates on entry to DONE.
REQ-027 load_data SHALL hold its value until the next successful load completes; stores SHALL not alter it.
REQ-028 Dword store path SHALL be IDLE->WRITE->DONE with mem_wdata=store_data and no read; done at start+2.
REQ-029 Sub-dword store path SHALL be IDLE->READ->WAIT->WRITE->DONE; done at start+4.
REQ-030 Store merge: mem_wdata equals the captured dword with bytes [offset .. offset+n-1] replaced by store_data bytes [0 .. n-1]; all other bytes unchanged.
REQ-031 WRITE SHALL drive mem_wr=1 for exactly one cycle; mem_rd and mem_wr SHALL never be high together.
REQ-032 mem_addr SHALL be stable throughout READ, WAIT and WRITE.
REQ-033 DONE SHALL last exactly one cycle and return to IDLE; a new start is accepted no earlier than the cycle after DONE.
REQ-034 misaligned=1 with sign_ext or op_store in any combination SHALL take the same 1-cycle path.

Reset
REQ-035 reset=0 at a clock edge SHALL force IDLE and clear busy, done, misaligned, mem_rd, mem_wr, mem_wdata, mem_addr, load_data and all latched fields to 0.
REQ-036 Reset asserted mid-operation (any state) SHALL abort with no further mem_wr or done; the cycle after reset deasserts is IDLE.
REQ-037 reset=0 SHALL take priority over start in the same cycle.

Verification
REQ-038 Load byte signed: mem at 0x100 = 0x0000_0000_0000_8000, addr=0x101, size=0, sign_ext=1 -> mem_rd at start+1, done at start+3, load_data=0xFFFF_FFFF_FFFF_FF80.
REQ-039 Store half: mem at 0x200 = 0x1122_3344_5566_7788, addr=0x204, store_data=0xABCD -> one mem_wr, mem_wdata=0x1122_ABCD_5566_7788, done at start+4.
REQ-040 Store dword: addr=0x308, store_data=0xDEAD_BEEF_0000_0001 -> no mem_rd, mem_wr at start+1 with mem_addr=0x308, done at start+2.
REQ-041 Misaligned word load: addr=0x102, size=2 -> done and misaligned high at start+1, no mem strobes, load_data unchanged.
REQ-042 Reset mid-store: assert reset=0 during WAIT of a sub-dword store -> mem_wr never asserts, busy=0 next cycle, all outputs 0.
REQ-043 Start while busy: second start pulse during READ -> ignored, exactly one done pulse produced.
